fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the 16-bit multicycle processor. It owns the program counter, runs a read handshake against instruction memory, and delivers the fetched word with a one-cycle write strobe. That strobe drives the write flag of the 16-bit instruction register that sits directly downstream. It also handles branch redirects and flags a sticky fault when memory never answers.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_STEP, 2, increment applied after each completed fetch (byte-addressed, 16-bit instructions)
- TIMEOUT, 15, max WAIT cycles without mem_ready before fault; 0 disables timeout

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  request one fetch; sampled in IDLE and DONE only
- branch_valid  in  1  load PC from branch_target
- branch_target  in  16  redirect address; bit 0 forced to 0
- mem_addr  out  16  instruction memory address (= pc)
- mem_rd  out  1  memory read request, held high through WAIT
- mem_rdata  in  16  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory read complete
- ir_data  out  16  fetched instruction, feeds instruction register input
- ir_w  out  1  one-cycle write strobe to instruction register
- pc_fetched  out  16  address of the word currently in ir_data
- busy  out  1  high in WAIT
- fault  out  1  sticky memory-timeout flag

## Operation
- States: IDLE, WAIT, DONE, FAULT. All outputs registered except mem_addr (= pc).
- Reset (any state, any cycle): state=IDLE, pc=RESET_PC, ir_data=0, pc_fetched=0, ir_w=0, mem_rd=0, busy=0, fault=0, timeout counter=0, pending-branch cleared. A fetch in flight is abandoned; a mem_ready arriving afterwards is ignored.
- IDLE/DONE: branch_valid → pc=branch_target&16'hFFFE. fetch_req → WAIT, mem_rd=1, busy=1. If both arrive in the same cycle, the fetch uses the branch target. No fetch_req → IDLE.
- WAIT: mem_ready=1 → DONE. ir_data=mem_rdata, pc_fetched=pc, ir_w=1, mem_rd=0, busy=0. pc = pending-branch target if one is set, else pc+PC_STEP (mod 2^16, wraps FFFE→0000). Pending cleared.
- WAIT, branch_valid: target stored as pending. The current fetch completes from the old address. Last branch wins. A branch arriving in the same cycle as mem_ready is also taken as pending and applied.
- WAIT, mem_ready=0: counter increments. When counter reaches TIMEOUT with TIMEOUT≠0 → FAULT.
- DONE lasts exactly one cycle. ir_w is high only in DONE.
- FAULT: mem_rd=0, busy=0, fault=1, ir_w=0. fetch_req and branch_valid are ignored. Only reset exits.
- mem_ready is ignored outside WAIT. fetch_req is ignored in WAIT and FAULT (not queued).

## Timing
- fetch_req sampled high at edge N → mem_rd=1 from cycle N+1.
- mem_ready sampled high at edge M → ir_w=1, ir_data valid, pc updated in cycle M+1. The instruction register captures at edge M+1.
- Minimum fetch_req→ir_w latency is 2 cycles (ready on first WAIT cycle).
- Back-to-back: fetch_req high during DONE → mem_rd re-asserts in the next cycle. Sustained throughput is one instruction per 2 cycles with zero-wait memory.
- Timeout: the counter resets on entry to WAIT. mem_ready on WAIT cycle TIMEOUT still completes normally. If ready is low for TIMEOUT consecutive cycles → fault=1 on cycle TIMEOUT+1.
- mem_addr is stable for the whole of WAIT.

## Test plan
- Reset then fetch_req, mem_ready on first WAIT cycle, mem_rdata=16'h1234 → ir_w pulse 2 cycles after req, ir_data=1234, pc_fetched=0000, pc=0002.
- Three back-to-back fetches with zero-wait memory → ir_w every 2 cycles, mem_addr 0000/0002/0004, final pc=0006.
- branch_valid=1, target=16'h0A11, together with fetch_req in IDLE → mem_addr=0A10, completed pc=0A12. Branch to 0200 during a 3-cycle WAIT at 0004 → ir_data from 0004, pc=0200.
- pc=FFFE fetch → pc wraps to 0000, pc_fetched=FFFE.
- TIMEOUT=15, mem_ready held low → fault=1 on WAIT cycle 16, mem_rd=0, fetch_req ignored. Reset clears fault, pc=RESET_PC. With mem_ready on cycle 15 instead → normal completion.
- Reset asserted mid-WAIT, then mem_ready pulsed → no ir_w, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit multicycle processor.
// It owns the program counter and runs a read handshake against instruction
// memory. Each fetched word is delivered with a one-cycle ir_w strobe for the
// downstream instruction register. Branches taken while a read is outstanding
// are held as pending and applied when that read completes. A sticky fault is
// raised when memory stays silent for TIMEOUT consecutive wait cycles.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] ir_data,
    output logic        ir_w,
    output logic [15:0] pc_fetched,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [15:0] PC_STEP_C  = 16'(PC_STEP);
    localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
    localparam logic        TIMEOUT_EN = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_data_q, ir_data_d;
    logic [15:0] pc_fetched_q, pc_fetched_d;
    logic        ir_w_q, ir_w_d;
    logic        mem_rd_q, mem_rd_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [15:0] pend_tgt_q, pend_tgt_d;

    logic [15:0] tgt_s;
    logic [15:0] cnt_inc_s;

    // Halfword-align the branch target and precompute the next timeout count.
    always_comb begin
        tgt_s     = branch_target & 16'hFFFE;
        cnt_inc_s = cnt_q + 16'd1;
    end

    // Next-state and registered-output logic for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_data_d    = ir_data_q;
        pc_fetched_d = pc_fetched_q;
        ir_w_d       = 1'b0;
        mem_rd_d     = 1'b0;
        busy_d       = 1'b0;
        fault_d      = fault_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A redirect lands in pc this edge, so a simultaneous fetch uses it.
                if (branch_valid) begin
                    pc_d = tgt_s;
                end else begin
                    pc_d = pc_q;
                end
                if (fetch_req) begin
                    state_d  = ST_WAIT;
                    mem_rd_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = 16'd0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d      = ST_DONE;
                    ir_data_d    = mem_rdata;
                    pc_fetched_d = pc_q;
                    ir_w_d       = 1'b1;
                    cnt_d        = 16'd0;
                    pend_d       = 1'b0;
                    // The newest redirect wins over an older pending one.
                    if (branch_valid) begin
                        pc_d = tgt_s;
                    end else if (pend_q) begin
                        pc_d = pend_tgt_q;
                    end else begin
                        pc_d = pc_q + PC_STEP_C;
                    end
                end else begin
                    // mem_addr must stay put during WAIT; park the redirect.
                    if (branch_valid) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = tgt_s;
                    end else begin
                        pend_d     = pend_q;
                    end
                    if (TIMEOUT_EN && (cnt_inc_s == TIMEOUT_C)) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d  = ST_WAIT;
                        mem_rd_d = 1'b1;
                        busy_d   = 1'b1;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_inc_s;
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end
                end
            end
            ST_FAULT: begin
                // Terminal until reset; all requests are ignored.
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            ir_data_q    <= 16'h0000;
            pc_fetched_q <= 16'h0000;
            ir_w_q       <= 1'b0;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            cnt_q        <= 16'd0;
            pend_q       <= 1'b0;
            pend_tgt_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_data_q    <= ir_data_d;
            pc_fetched_q <= pc_fetched_d;
            ir_w_q       <= ir_w_d;
            mem_rd_q     <= mem_rd_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    assign mem_addr   = pc_q;
    assign mem_rd     = mem_rd_q;
    assign ir_data    = ir_data_q;
    assign ir_w       = ir_w_q;
    assign pc_fetched = pc_fetched_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

endmodule
